// File: rtl/chart_feeder_if.sv
// Host-entry handshake and core write bus of the chart feeder.
// The feeder takes the master view; the host/core side takes the slave view.
interface chart_feeder_if;
    logic        in_valid;
    logic        in_ready;
    logic [17:0] in_entry;
    logic        write;
    logic [1:0]  address;
    logic [17:0] pattern_with_timestamp;
    logic [7:0]  user_input;

    modport master (
        input  in_valid,
        input  in_entry,
        output in_ready,
        output write,
        output address,
        output pattern_with_timestamp,
        output user_input
    );

    modport slave (
        output in_valid,
        output in_entry,
        input  in_ready,
        input  write,
        input  address,
        input  pattern_with_timestamp,
        input  user_input
    );
endinterface

// File: rtl/chart_feeder.sv
// Buffers host chart entries and issues them to the game core LEAD ticks ahead of
// their timestamp, interleaving button-change writes that take priority.
module chart_feeder #(
    parameter int         DEPTH        = 8,
    parameter int         LEAD         = 4,
    parameter logic [1:0] ADDR_PATTERN = 2'd0,
    parameter logic [1:0] ADDR_USER    = 2'd1
) (
    input  logic                     CLOCK50M,
    input  logic                     RESET_N,
    input  logic                     flush,
    input  logic [9:0]               game_time,
    input  logic [7:0]               user_keys,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     late_drop,
    chart_feeder_if.master           bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, GAP} state_t;

    state_t          state_reg;
    logic [17:0]     mem [DEPTH];
    logic [AW-1:0]   rd_ptr_reg;
    logic [AW-1:0]   wr_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic [CW-1:0]   count_next;
    logic            in_ready_reg;
    logic            pending_reg;
    logic [7:0]      last_sent_reg;
    logic            write_reg;
    logic            late_drop_reg;
    logic [1:0]      address_reg;
    logic [17:0]     pattern_reg;
    logic [7:0]      user_input_reg;

    logic [17:0]     head_entry;
    logic [10:0]     head_ts;
    logic [10:0]     now_ts;
    logic [10:0]     horizon_ts;
    logic            non_empty;
    logic            due;
    logic            stale;
    logic            key_change;
    logic            in_idle;
    logic            issue_user;
    logic            issue_pattern;
    logic            drop_head;
    logic            push;
    logic            pop;

    // The head is read combinationally so a due entry can be issued on the very
    // next edge; the FIFO is small enough for distributed storage.
    assign head_entry = mem[rd_ptr_reg];

    always_comb begin
        head_ts       = {1'b0, head_entry[17:8]};
        now_ts        = {1'b0, game_time};
        horizon_ts    = now_ts + 11'(LEAD);
        non_empty     = (count_reg != '0);
        due           = non_empty && (head_ts <= horizon_ts);
        stale         = non_empty && (head_ts < now_ts);
        key_change    = (user_keys != last_sent_reg);
        in_idle       = (state_reg == IDLE) && !flush;
        // A key change seen this very cycle already wins over a due pattern.
        issue_user    = in_idle && (pending_reg || key_change);
        drop_head     = in_idle && !issue_user && stale;
        issue_pattern = in_idle && !issue_user && !stale && due;
        pop           = drop_head || issue_pattern;
        push          = bus.in_valid && in_ready_reg && !flush;
        if (flush) begin
            count_next = '0;
        end else begin
            count_next = count_reg + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge CLOCK50M) begin
        if (push) begin
            mem[wr_ptr_reg] <= bus.in_entry;
        end
    end

    always_ff @(posedge CLOCK50M or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg      <= IDLE;
            rd_ptr_reg     <= '0;
            wr_ptr_reg     <= '0;
            count_reg      <= '0;
            in_ready_reg   <= 1'b0;
            pending_reg    <= 1'b0;
            last_sent_reg  <= '0;
            write_reg      <= 1'b0;
            late_drop_reg  <= 1'b0;
            address_reg    <= '0;
            pattern_reg    <= '0;
            user_input_reg <= '0;
        end else begin
            count_reg     <= count_next;
            in_ready_reg  <= !flush && (count_next < CW'(DEPTH));
            write_reg     <= 1'b0;
            late_drop_reg <= 1'b0;
            if (flush) begin
                // last_sent survives so unchanged keys are not re-sent after restart.
                rd_ptr_reg  <= '0;
                wr_ptr_reg  <= '0;
                pending_reg <= 1'b0;
                state_reg   <= IDLE;
            end else begin
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + 1'b1;
                end
                case (state_reg)
                    IDLE: begin
                        if (issue_user) begin
                            address_reg    <= ADDR_USER;
                            user_input_reg <= user_keys;
                            write_reg      <= 1'b1;
                            last_sent_reg  <= user_keys;
                            pending_reg    <= 1'b0;
                            state_reg      <= GAP;
                        end else if (drop_head) begin
                            late_drop_reg <= 1'b1;
                        end else if (issue_pattern) begin
                            address_reg <= ADDR_PATTERN;
                            pattern_reg <= head_entry;
                            write_reg   <= 1'b1;
                            state_reg   <= GAP;
                        end
                    end
                    GAP: begin
                        // The newest key level is sampled when the write is finally issued.
                        if (key_change) begin
                            pending_reg <= 1'b1;
                        end
                        state_reg <= IDLE;
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign bus.in_ready               = in_ready_reg;
    assign bus.write                  = write_reg;
    assign bus.address                = address_reg;
    assign bus.pattern_with_timestamp = pattern_reg;
    assign bus.user_input             = user_input_reg;
    assign fifo_count                 = count_reg;
    assign late_drop                  = late_drop_reg;
endmodule

// File: tb/tb_chart_feeder.sv
// Directed bench for chart_feeder: stimulus queues expected bus events, a
// negedge monitor pops and compares them whenever write or late_drop is seen.
module tb_chart_feeder;
    logic       CLOCK50M;
    logic       RESET_N;
    logic       flush;
    logic [9:0] game_time;
    logic [7:0] user_keys;
    logic [3:0] fifo_count;
    logic       late_drop;

    chart_feeder_if bus();

    chart_feeder #(.DEPTH(8), .LEAD(4), .ADDR_PATTERN(2'd0), .ADDR_USER(2'd1)) dut (
        .CLOCK50M   (CLOCK50M),
        .RESET_N    (RESET_N),
        .flush      (flush),
        .game_time  (game_time),
        .user_keys  (user_keys),
        .fifo_count (fifo_count),
        .late_drop  (late_drop),
        .bus        (bus)
    );

    typedef struct packed {
        logic [1:0]  kind;   // 0 pattern, 1 user, 2 drop
        logic [17:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    initial CLOCK50M = 1'b0;
    always #5 CLOCK50M = ~CLOCK50M;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_pat(input logic [9:0] ts, input logic [7:0] pat);
        exp_q.push_back('{kind: 2'd0, data: {ts, pat}});
    endtask

    task automatic expect_user(input logic [7:0] keys);
        exp_q.push_back('{kind: 2'd1, data: {10'd0, keys}});
    endtask

    task automatic expect_drop();
        exp_q.push_back('{kind: 2'd2, data: 18'd0});
    endtask

    // Monitor: every strobe or drop pulse must match the oldest expectation.
    always @(negedge CLOCK50M) begin
        if (bus.write || late_drop) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: write=%0b addr=%0d pwt=%05h user=%02h drop=%0b",
                         bus.write, bus.address, bus.pattern_with_timestamp, bus.user_input, late_drop);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("event kind=%0d write=%0b addr=%0d pwt=%05h user=%02h drop=%0b",
                         e.kind, bus.write, bus.address, bus.pattern_with_timestamp,
                         bus.user_input, late_drop);
                case (e.kind)
                    2'd0: begin
                        check("pat_write", 32'(bus.write), 32'd1);
                        check("pat_addr", 32'(bus.address), 32'd0);
                        check("pat_data", 32'(bus.pattern_with_timestamp), 32'(e.data));
                    end
                    2'd1: begin
                        check("user_write", 32'(bus.write), 32'd1);
                        check("user_addr", 32'(bus.address), 32'd1);
                        check("user_data", 32'(bus.user_input), 32'(e.data[7:0]));
                    end
                    default: begin
                        check("drop_pulse", 32'(late_drop), 32'd1);
                        check("drop_no_write", 32'(bus.write), 32'd0);
                    end
                endcase
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_N      = 1'b1;
        flush        = 1'b0;
        game_time    = 10'd0;
        user_keys    = 8'd0;
        bus.in_valid = 1'b0;
        bus.in_entry = 18'd0;
        #1 RESET_N = 1'b0;
        repeat (3) @(negedge CLOCK50M);

        // Reset state
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_write", 32'(bus.write), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_drop", 32'(late_drop), 32'd0);
        check("rst_addr", 32'(bus.address), 32'd0);
        check("rst_pwt", 32'(bus.pattern_with_timestamp), 32'd0);
        check("rst_user", 32'(bus.user_input), 32'd0);
        RESET_N = 1'b1;
        #1 check("rel_in_ready_low", 32'(bus.in_ready), 32'd0);
        @(negedge CLOCK50M);
        check("rel_in_ready_high", 32'(bus.in_ready), 32'd1);

        // Fill and hold: 8 entries ts 100..107 at game_time 0
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_entry = {10'(100 + i), 8'(8'h10 + i)};
            @(negedge CLOCK50M);
        end
        check("fill_count", 32'(fifo_count), 32'd8);
        check("fill_in_ready", 32'(bus.in_ready), 32'd0);
        bus.in_entry = {10'd108, 8'h18};
        for (int i = 0; i < 3; i++) begin
            @(negedge CLOCK50M);
            check("hold_count", 32'(fifo_count), 32'd8);
            check("hold_write", 32'(bus.write), 32'd0);
        end
        bus.in_valid = 1'b0;

        // Drain: at game_time 104, ts 100..103 are stale, 104..107 are due
        for (int i = 0; i < 4; i++) expect_drop();
        for (int i = 4; i < 8; i++) expect_pat(10'(100 + i), 8'(8'h10 + i));
        game_time = 10'd104;
        repeat (16) @(negedge CLOCK50M);
        check("drain_count", 32'(fifo_count), 32'd0);

        // Lead release: ts 50 goes out in the cycle after game_time reaches 46
        game_time    = 10'd40;
        bus.in_valid = 1'b1;
        bus.in_entry = {10'd50, 8'hA5};
        expect_pat(10'd50, 8'hA5);
        @(negedge CLOCK50M);
        bus.in_valid = 1'b0;
        for (int g = 40; g <= 50; g++) begin
            game_time = 10'(g);
            @(negedge CLOCK50M);
            check("lead_write", 32'(bus.write), 32'(g == 46));
            if (g == 46) check("lead_data", 32'(bus.pattern_with_timestamp), 32'h032A5);
        end
        check("lead_count", 32'(fifo_count), 32'd0);

        // Stale drop
        game_time    = 10'd20;
        bus.in_valid = 1'b1;
        bus.in_entry = {10'd10, 8'h5A};
        expect_drop();
        @(negedge CLOCK50M);
        bus.in_valid = 1'b0;
        check("stale_count_pre", 32'(fifo_count), 32'd1);
        check("stale_drop_pre", 32'(late_drop), 32'd0);
        @(negedge CLOCK50M);
        check("stale_drop", 32'(late_drop), 32'd1);
        check("stale_count", 32'(fifo_count), 32'd0);
        @(negedge CLOCK50M);
        check("stale_drop_end", 32'(late_drop), 32'd0);

        // Priority and gap: user write first, then the pattern two cycles later
        game_time    = 10'd100;
        bus.in_valid = 1'b1;
        bus.in_entry = {10'd200, 8'h3C};
        @(negedge CLOCK50M);
        bus.in_valid = 1'b0;
        @(negedge CLOCK50M);
        expect_user(8'h01);
        expect_pat(10'd200, 8'h3C);
        game_time = 10'd196;
        user_keys = 8'h01;
        @(negedge CLOCK50M);
        check("prio_w1", 32'(bus.write), 32'd1);
        check("prio_a1", 32'(bus.address), 32'd1);
        @(negedge CLOCK50M);
        check("prio_gap", 32'(bus.write), 32'd0);
        @(negedge CLOCK50M);
        check("prio_w2", 32'(bus.write), 32'd1);
        check("prio_a2", 32'(bus.address), 32'd0);
        expect_user(8'h00);
        user_keys = 8'h00;
        repeat (4) @(negedge CLOCK50M);

        // Key coalescing: 00->01->03 while the pattern write is in flight
        game_time    = 10'd250;
        bus.in_valid = 1'b1;
        bus.in_entry = {10'd300, 8'h77};
        @(negedge CLOCK50M);
        bus.in_valid = 1'b0;
        expect_pat(10'd300, 8'h77);
        expect_user(8'h03);
        game_time = 10'd296;
        @(negedge CLOCK50M);
        check("coal_pat", 32'(bus.write), 32'd1);
        user_keys = 8'h01;
        @(negedge CLOCK50M);
        check("coal_gap", 32'(bus.write), 32'd0);
        user_keys = 8'h03;
        @(negedge CLOCK50M);
        check("coal_user_w", 32'(bus.write), 32'd1);
        check("coal_user_v", 32'(bus.user_input), 32'h03);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLOCK50M);
            check("coal_quiet", 32'(bus.write), 32'd0);
        end

        // Flush with a push in the same cycle and 3 entries buffered
        game_time = 10'd0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_entry = {10'(500 + i), 8'(8'h20 + i)};
            @(negedge CLOCK50M);
        end
        check("flush_pre_count", 32'(fifo_count), 32'd3);
        flush        = 1'b1;
        bus.in_entry = {10'd510, 8'h2F};
        @(negedge CLOCK50M);
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_count", 32'(fifo_count), 32'd0);
        check("flush_write", 32'(bus.write), 32'd0);
        repeat (2) @(negedge CLOCK50M);
        check("flush_count_after", 32'(fifo_count), 32'd0);
        check("flush_in_ready", 32'(bus.in_ready), 32'd1);

        // Reset asserted in the middle of GAP
        bus.in_valid = 1'b1;
        bus.in_entry = {10'd2, 8'h99};
        expect_pat(10'd2, 8'h99);
        @(negedge CLOCK50M);
        bus.in_valid = 1'b0;
        @(negedge CLOCK50M);
        check("mid_write", 32'(bus.write), 32'd1);
        #2 RESET_N = 1'b0;
        user_keys = 8'h00;
        #1;
        check("async_write", 32'(bus.write), 32'd0);
        check("async_in_ready", 32'(bus.in_ready), 32'd0);
        check("async_pwt", 32'(bus.pattern_with_timestamp), 32'd0);
        check("async_user", 32'(bus.user_input), 32'd0);
        check("async_count", 32'(fifo_count), 32'd0);
        @(negedge CLOCK50M);
        RESET_N = 1'b1;
        #1 check("rel2_in_ready_low", 32'(bus.in_ready), 32'd0);
        @(negedge CLOCK50M);
        check("rel2_in_ready_high", 32'(bus.in_ready), 32'd1);
        check("rel2_write", 32'(bus.write), 32'd0);

        repeat (3) @(negedge CLOCK50M);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/chart_feeder.md
Name: chart_feeder

Overview:
- Upstream stage of the game core. Feeds the core's write / address / pattern_with_timestamp / user_input bus.
- Accepts chart entries {timestamp[9:0], pattern[7:0]} from the host over a valid/ready handshake and buffers them in a FIFO.
- Releases each entry to the core LEAD game ticks before its timestamp.
- Interleaves button-change writes from the user key path, with user writes taking priority.

Parameters:
- DEPTH, 8: FIFO entries; power of two, 2..16.
- LEAD, 4: game ticks of look-ahead before an entry's timestamp at which it is issued.
- ADDR_PATTERN, 2'd0: bus address used for pattern writes.
- ADDR_USER, 2'd1: bus address used for user-input writes.

Ports:
- CLOCK50M, input, 1: system clock; all logic is on the rising edge.
- RESET_N, input, 1: asynchronous active-low reset.
- flush, input, 1: synchronous clear of FIFO and pending user write (asserted on game restart).
- in_valid, input, 1: host entry valid.
- in_ready, output, 1: FIFO can accept an entry (registered).
- in_entry, input, 18: [17:8] timestamp, [7:0] pattern.
- game_time, input, 10: current game tick (counter10h), synchronous to CLOCK50M.
- user_keys, input, 8: already-synchronized button levels.
- write, output, 1: one-cycle bus write strobe.
- address, output, 2: bus address; valid while write=1.
- pattern_with_timestamp, output, 18: pattern write data; holds its last value.
- user_input, output, 8: user write data; holds its last value.
- fifo_count, output, log2(DEPTH)+1: current FIFO occupancy.
- late_drop, output, 1: one-cycle pulse when the head entry is discarded as stale.

Behaviour:
- Reset (RESET_N low, asynchronous):
  - All outputs are 0, including in_ready.
  - FIFO is empty; pending user write is cleared; last-sent key register is 0; FSM is in IDLE.
  - in_ready rises on the first clock edge after RESET_N deasserts.
- FIFO push:
  - An entry is accepted on a clock edge with in_valid && in_ready.
  - in_ready is registered and equals (count_next < DEPTH).
  - When full, in_ready=0 and in_entry is ignored; the host holds it.
  - Push and pop in the same cycle are allowed; count is unchanged.
- Timing arithmetic: all comparisons are 11-bit unsigned, with no wrap.
  - due = head_ts <= game_time + LEAD.
  - stale = head_ts < game_time.
  - Both are evaluated only when the FIFO is non-empty.
- User key tracking:
  - When user_keys != last_sent and no user write is pending, set pending and latch user_keys.
  - If keys change again while pending, the latched value updates to the newest user_keys. Only the most recent value is sent.
- FSM states:
  - IDLE:
    - If pending: drive address=ADDR_USER, user_input=latched value, write=1; set last_sent; clear pending; go to GAP.
    - Else if the FIFO is non-empty and stale: pop, pulse late_drop, no write, stay in IDLE.
    - Else if the FIFO is non-empty and due: pop, drive address=ADDR_PATTERN, pattern_with_timestamp=head entry, write=1; go to GAP.
  - GAP: write=0 for exactly one cycle, then return to IDLE. This guarantees at least one idle cycle between strobes.
  - Maximum write rate is one every 2 cycles. Write latency from a due condition in IDLE is 1 cycle (outputs are registered).
- Ordering:
  - Entries leave in push order. The host is responsible for non-decreasing timestamps.
  - An out-of-order entry that is already stale when it reaches the head is dropped.
- flush:
  - On the edge where flush=1: count becomes 0, pending clears, the FSM goes to IDLE, write=0.
  - A push in the same cycle is discarded. in_ready is 0 that cycle.
  - last_sent is kept, so unchanged keys do not re-send.
- Reset mid-write: the strobe aborts immediately; no partial state survives.
- A game_time jump backwards has no special handling. Entries simply become not-due.

Test Plan:
- Fill and hold: push 8 entries with timestamps 100..107 at game_time=0 -> fifo_count=8, in_ready=0 on the cycle after the 8th push; a 9th in_valid is held and not accepted; write stays 0.
- Lead release: one entry {ts=50, pat=8'hA5}; step game_time 40..50 -> single write with address=0, pattern_with_timestamp=18'h032A5 in the cycle after game_time reaches 46; fifo_count returns to 0.
- Stale drop: push ts=10 while game_time=20 -> late_drop pulses one cycle, no write, fifo_count=0.
- Priority and gap: a pattern is due and user_keys changes 00->01 in the same cycle -> user write (address=1, user_input=01) first, one gap cycle, then the pattern write; the two strobes are 2 cycles apart.
- Key coalescing: user_keys 00->01->03 on consecutive cycles while a write is pending -> exactly one user write, carrying 03.
- Flush/reset: flush together with in_valid and 3 entries buffered -> fifo_count=0 next cycle, no write, entry not accepted; RESET_N pulsed mid-GAP -> all outputs 0 asynchronously, in_ready=1 one edge after release.
